// File: rtl/fetch_pc_unit_if.sv
// Fetch front-end bus: EX resolution/redirect inputs, imem address and IF/ID capture fields.
// The master modport is the fetch unit; the slave modport is the surrounding pipeline/memory.
interface fetch_pc_unit_if;
  logic        pipeline_en;
  logic        ex_redirect;
  logic [31:0] ex_redirect_pc;
  logic        ex_update_en;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic [31:0] imem_addr;
  logic [31:0] if_pc;
  logic        if_pred_valid;
  logic        if_pred_taken;
  logic [31:0] if_predicted_pc;
  logic        if_flush;

  modport master (
    input  pipeline_en, ex_redirect, ex_redirect_pc,
    input  ex_update_en, ex_pc, ex_taken, ex_target,
    output imem_addr, if_pc, if_pred_valid, if_pred_taken, if_predicted_pc, if_flush
  );

  modport slave (
    output pipeline_en, ex_redirect, ex_redirect_pc,
    output ex_update_en, ex_pc, ex_taken, ex_target,
    input  imem_addr, if_pc, if_pred_valid, if_pred_taken, if_predicted_pc, if_flush
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: PC register, next-PC select and a direct-mapped BTB with 2-bit counters.
// imem_addr is pc_next so the registered imem output lines up with if_pc one cycle later.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16,
  parameter int          IDX_W       = 4
) (
  input  logic            clk,
  input  logic            rst,
  fetch_pc_unit_if.master bus
);
  localparam int TAG_W = 30 - IDX_W;

  logic [31:0]      pc_q;
  logic             pred_valid_q;
  logic             pred_taken_q;
  logic [31:0]      pred_pc_q;
  logic             flush_q;

  logic             btb_valid_q  [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag_q    [BTB_ENTRIES];
  logic [31:0]      btb_target_q [BTB_ENTRIES];
  logic [1:0]       btb_cnt_q    [BTB_ENTRIES];

  logic [31:0]      pc_d;
  logic [IDX_W-1:0] lk_idx;
  logic             lk_hit;
  logic [IDX_W-1:0] up_idx;
  logic             up_hit;

  always_comb begin
    pc_d = pc_q + 32'd4;
    if (rst)                   pc_d = RESET_PC;
    else if (bus.ex_redirect)  pc_d = bus.ex_redirect_pc;
    else if (!bus.pipeline_en) pc_d = pc_q;
    else if (pred_taken_q)     pc_d = pred_pc_q;
  end

  // Lookup reads pre-update BTB contents; a same-cycle update is seen next lookup.
  always_comb begin
    lk_idx = pc_d[IDX_W+1:2];
    lk_hit = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == pc_d[31:IDX_W+2]);
    up_idx = bus.ex_pc[IDX_W+1:2];
    up_hit = btb_valid_q[up_idx] && (btb_tag_q[up_idx] == bus.ex_pc[31:IDX_W+2]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_pc_q    <= 32'd0;
      flush_q      <= 1'b1;
    end else begin
      pc_q <= pc_d;
      // A plain stall keeps the captured prediction even if the BTB changed meanwhile.
      if (bus.ex_redirect || bus.pipeline_en) begin
        pred_valid_q <= lk_hit;
        pred_taken_q <= lk_hit && btb_cnt_q[lk_idx][1];
        pred_pc_q    <= lk_hit ? btb_target_q[lk_idx] : 32'd0;
      end
      if (bus.pipeline_en) flush_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid_q[i]  <= 1'b0;
        btb_tag_q[i]    <= '0;
        btb_target_q[i] <= 32'd0;
        btb_cnt_q[i]    <= 2'b01;
      end
    end else if (bus.ex_update_en) begin
      if (up_hit) begin
        if (bus.ex_taken) begin
          btb_target_q[up_idx] <= bus.ex_target;
          if (btb_cnt_q[up_idx] != 2'b11) btb_cnt_q[up_idx] <= btb_cnt_q[up_idx] + 2'b01;
        end else if (btb_cnt_q[up_idx] != 2'b00) begin
          btb_cnt_q[up_idx] <= btb_cnt_q[up_idx] - 2'b01;
        end
      end else if (bus.ex_taken) begin
        btb_valid_q[up_idx]  <= 1'b1;
        btb_tag_q[up_idx]    <= bus.ex_pc[31:IDX_W+2];
        btb_target_q[up_idx] <= bus.ex_target;
        btb_cnt_q[up_idx]    <= 2'b10;
      end
    end
  end

  assign bus.imem_addr       = pc_d;
  assign bus.if_pc           = pc_q;
  assign bus.if_pred_valid   = pred_valid_q;
  assign bus.if_pred_taken   = pred_taken_q;
  assign bus.if_predicted_pc = pred_pc_q;
  assign bus.if_flush        = flush_q;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed table-driven bench for fetch_pc_unit: each row is one clock of inputs plus the
// expected combinational imem_addr and the registered IF/ID fields after the edge.
module tb_fetch_pc_unit;
  logic clk;
  logic rst;
  fetch_pc_unit_if ifc ();

  fetch_pc_unit #(
    .RESET_PC   (32'h0000_0000),
    .BTB_ENTRIES(16),
    .IDX_W      (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rst, en, redir, rpc, upd, epc, tk, tgt;
    logic [31:0] e_addr, e_pc, e_pv, e_pt, e_ppc, e_fl;
  } vec_t;

  vec_t rows[$];
  int   checks;
  int   errors;

  task automatic chk(input string name, input int row, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h want %h", name, row, got, exp);
    end
  endtask

  task automatic run_rows(input string seq);
    foreach (rows[i]) begin
      rst                = rows[i].rst[0];
      ifc.pipeline_en    = rows[i].en[0];
      ifc.ex_redirect    = rows[i].redir[0];
      ifc.ex_redirect_pc = rows[i].rpc;
      ifc.ex_update_en   = rows[i].upd[0];
      ifc.ex_pc          = rows[i].epc;
      ifc.ex_taken       = rows[i].tk[0];
      ifc.ex_target      = rows[i].tgt;
      #1;
      chk({seq, ".imem_addr"}, i, ifc.imem_addr, rows[i].e_addr);
      @(posedge clk);
      #1;
      chk({seq, ".if_pc"}, i, ifc.if_pc, rows[i].e_pc);
      chk({seq, ".if_pred_valid"}, i, {31'd0, ifc.if_pred_valid}, rows[i].e_pv);
      chk({seq, ".if_pred_taken"}, i, {31'd0, ifc.if_pred_taken}, rows[i].e_pt);
      chk({seq, ".if_predicted_pc"}, i, ifc.if_predicted_pc, rows[i].e_ppc);
      chk({seq, ".if_flush"}, i, {31'd0, ifc.if_flush}, rows[i].e_fl);
    end
    rows.delete();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    ifc.pipeline_en = 1'b0; ifc.ex_redirect = 1'b0; ifc.ex_redirect_pc = 32'd0;
    ifc.ex_update_en = 1'b0; ifc.ex_pc = 32'd0; ifc.ex_taken = 1'b0; ifc.ex_target = 32'd0;

    // rst en redir rpc upd ex_pc tk tgt | addr pc pv pt ppc flush
    // Reset, free run, allocate 0x10->0x80, train down to 00, up to saturation.
    rows.push_back('{1,1,0,0,     0,0,    0,0,      0,    0,    0,0,0,    1});
    rows.push_back('{1,0,0,0,     0,0,    0,0,      0,    0,    0,0,0,    1});
    rows.push_back('{0,1,0,0,     0,0,    0,0,      4,    4,    0,0,0,    0});
    rows.push_back('{0,1,0,0,     0,0,    0,0,      8,    8,    0,0,0,    0});
    rows.push_back('{0,1,0,0,     1,'h10, 1,'h80,   'hC,  'hC,  0,0,0,    0});
    rows.push_back('{0,1,0,0,     0,0,    0,0,      'h10, 'h10, 1,1,'h80, 0});
    rows.push_back('{0,1,0,0,     0,0,    0,0,      'h80, 'h80, 0,0,0,    0});
    rows.push_back('{0,1,0,0,     0,0,    0,0,      'h84, 'h84, 0,0,0,    0});
    rows.push_back('{0,1,1,'h10,  1,'h10, 0,0,      'h10, 'h10, 1,1,'h80, 0});
    rows.push_back('{0,1,1,'h10,  1,'h10, 0,0,      'h10, 'h10, 1,0,'h80, 0});
    rows.push_back('{0,1,1,'h10,  0,0,    0,0,      'h10, 'h10, 1,0,'h80, 0});
    rows.push_back('{0,1,0,0,     0,0,    0,0,      'h14, 'h14, 0,0,0,    0});
    rows.push_back('{0,1,0,0,     1,'h10, 1,'h80,   'h18, 'h18, 0,0,0,    0});
    rows.push_back('{0,1,0,0,     1,'h10, 1,'h80,   'h1C, 'h1C, 0,0,0,    0});
    rows.push_back('{0,1,0,0,     1,'h10, 1,'h80,   'h20, 'h20, 0,0,0,    0});
    rows.push_back('{0,1,0,0,     1,'h10, 1,'h80,   'h24, 'h24, 0,0,0,    0});
    rows.push_back('{0,1,0,0,     1,'h10, 0,0,      'h28, 'h28, 0,0,0,    0});
    rows.push_back('{0,1,1,'h10,  0,0,    0,0,      'h10, 'h10, 1,1,'h80, 0});
    rows.push_back('{0,1,0,0,     0,0,    0,0,      'h80, 'h80, 0,0,0,    0});
    run_rows("main");

    // Tag alias at index 4: 0x50 misses, then replaces the 0x10 entry; stall holds prediction.
    rows.push_back('{0,1,1,'h50,  0,0,    0,0,      'h50, 'h50, 0,0,0,     0});
    rows.push_back('{0,1,0,0,     1,'h50, 1,'h200,  'h54, 'h54, 0,0,0,     0});
    rows.push_back('{0,1,1,'h10,  0,0,    0,0,      'h10, 'h10, 0,0,0,     0});
    rows.push_back('{0,1,1,'h50,  0,0,    0,0,      'h50, 'h50, 1,1,'h200, 0});
    rows.push_back('{0,0,0,0,     0,0,    0,0,      'h50, 'h50, 1,1,'h200, 0});
    rows.push_back('{0,1,0,0,     0,0,    0,0,      'h200,'h200,0,0,0,     0});
    run_rows("alias");

    // Stall three cycles at 0x20, then redirect while still stalled.
    rows.push_back('{0,1,1,'h20,  0,0,    0,0,      'h20, 'h20, 0,0,0, 0});
    rows.push_back('{0,0,0,0,     0,0,    0,0,      'h20, 'h20, 0,0,0, 0});
    rows.push_back('{0,0,0,0,     0,0,    0,0,      'h20, 'h20, 0,0,0, 0});
    rows.push_back('{0,0,0,0,     0,0,    0,0,      'h20, 'h20, 0,0,0, 0});
    rows.push_back('{0,0,1,'h100, 0,0,    0,0,      'h100,'h100,0,0,0, 0});
    rows.push_back('{0,1,0,0,     0,0,    0,0,      'h104,'h104,0,0,0, 0});
    run_rows("stall");

    // Reset during stall+redirect+update, BTB cleared, then read-before-write on 0x10.
    rows.push_back('{1,0,1,'h300, 1,'h10, 1,'h80,   0,    0,    0,0,0,    1});
    rows.push_back('{0,0,0,0,     0,0,    0,0,      0,    0,    0,0,0,    1});
    rows.push_back('{0,1,1,'h50,  0,0,    0,0,      'h50, 'h50, 0,0,0,    0});
    rows.push_back('{0,1,0,0,     1,'h10, 1,'h80,   'h54, 'h54, 0,0,0,    0});
    rows.push_back('{0,1,0,0,     1,'h10, 0,0,      'h58, 'h58, 0,0,0,    0});
    rows.push_back('{0,1,1,'h10,  1,'h10, 1,'h80,   'h10, 'h10, 1,0,'h80, 0});
    rows.push_back('{0,1,1,'h10,  0,0,    0,0,      'h10, 'h10, 1,1,'h80, 0});
    rows.push_back('{0,1,1,'hFFFFFFFC, 0,0, 0,0,    'hFFFFFFFC,'hFFFFFFFC,0,0,0,0});
    rows.push_back('{0,1,0,0,     0,0,    0,0,      0,    0,    0,0,0,    0});
    run_rows("rst_rbw");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
